rvm_ddr3_bridge: RTL



---
 rtl/rvm_ddr3_pkg.sv | 24 ++
 rtl/rvm_ddr3_line_buf.sv | 46 ++++
 rtl/rvm_ddr3_bridge.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rvm_ddr3_pkg.sv
// rtl/rvm_ddr3_pkg.sv - shared state encoding, DDR3 app-interface widths and lane helper
package rvm_ddr3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

    localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
    localparam logic [2:0] DDR_CMD_READ  = 3'b001;

    localparam int APP_ADDR_W = 28;
    localparam int APP_DATA_W = 128;
    localparam int APP_MASK_W = 16;

    // Byte enables of one 32-bit word placed into its lane of the 128-bit burst.
    function automatic logic [APP_MASK_W-1:0] lane_be(input logic [1:0] lane, input logic [3:0] be);
        return {12'b0, be} << {lane, 2'b00};
    endfunction

endpackage

// File: rtl/rvm_ddr3_line_buf.sv
// rtl/rvm_ddr3_line_buf.sv - single-entry 128-bit line buffer with tag compare and byte merge
module rvm_ddr3_line_buf
    import rvm_ddr3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic [23:0]           tag_i,
    output logic                  hit_o,
    output logic [APP_DATA_W-1:0] line_o,
    input  logic                  fill_i,
    input  logic [23:0]           fill_tag_i,
    input  logic [APP_DATA_W-1:0] fill_data_i,
    input  logic                  wr_i,
    input  logic [APP_DATA_W-1:0] wr_data_i,
    input  logic [APP_MASK_W-1:0] wr_be_i
);

    logic                  valid_q;
    logic [23:0]           tag_q;
    logic [APP_DATA_W-1:0] data_q;
    logic [APP_DATA_W-1:0] merged_d;

    assign hit_o  = valid_q & (tag_q == tag_i);
    assign line_o = data_q;

    always_comb begin
        merged_d = data_q;
        for (int i = 0; i < APP_MASK_W; i++) begin
            if (wr_be_i[i]) merged_d[i*8 +: 8] = wr_data_i[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
        end else if (wr_i && hit_o) begin
            data_q  <= merged_d;
        end
    end

endmodule

// File: rtl/rvm_ddr3_bridge.sv
// rtl/rvm_ddr3_bridge.sv - rvm_core word port to DDR3 app-interface bridge
// Optional single-line read buffer enabled by RVM_DDR3_LINE_BUF_EN.
module rvm_ddr3_bridge
    import rvm_ddr3_pkg::*;
#(
    parameter int MEM_BYTES_LOG2 = 28,
    parameter int RD_TIMEOUT     = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic                  mem_c_en,
    input  logic                  mem_w_en,
    input  logic [3:0]            mem_b_en,
    output logic [31:0]           mem_rdata,
    output logic                  mem_error,
    output logic                  mem_stall,
    input  logic                  init_calib_complete,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [APP_DATA_W-1:0] app_wdf_data,
    output logic [APP_MASK_W-1:0] app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    input  logic [APP_DATA_W-1:0] app_rd_data,
    input  logic                  app_rd_data_valid
);

    localparam int               CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_e           state_q;
    logic [25:0]      addr_q;       // mem_addr[27:2]
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [3:0]       be_q;
    logic             app_en_q, wdf_wren_q, mem_error_q;
    logic             cmd_done_q, dat_done_q;
    logic             cmd_done_d, dat_done_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       lane;
    logic             req, bad_addr, rd_hit;
    logic [31:0]      hit_word;

    assign lane     = addr_q[1:0];
    assign req      = mem_c_en & init_calib_complete;
    assign bad_addr = ((mem_addr >> MEM_BYTES_LOG2) != 32'd0) || (mem_addr[1:0] != 2'b00);

    assign app_addr     = {1'b0, addr_q[25:2], 3'b000};
    assign app_cmd      = (state_q == ST_WR) ? DDR_CMD_WRITE : DDR_CMD_READ;
    assign app_en       = app_en_q;
    assign app_wdf_data = {4{wdata_q}};
    assign app_wdf_mask = ~lane_be(lane, be_q);
    assign app_wdf_wren = wdf_wren_q;
    assign app_wdf_end  = wdf_wren_q;
    assign mem_rdata    = rdata_q;
    assign mem_error    = mem_error_q;
    assign mem_stall    = mem_c_en & (state_q != ST_RESP);

    // Command and data handshakes complete independently, possibly in the same cycle.
    always_comb begin
        cmd_done_d = cmd_done_q | (app_en_q & app_rdy);
        dat_done_d = dat_done_q | (wdf_wren_q & app_wdf_rdy);
    end

`ifdef RVM_DDR3_LINE_BUF_EN
    logic                  lb_hit, lb_clr, lb_fill, lb_wr;
    logic [APP_DATA_W-1:0] lb_line;

    assign lb_wr   = (state_q == ST_IDLE) & req & ~bad_addr & mem_w_en;
    assign lb_fill = (state_q == ST_RD_WAIT) & app_rd_data_valid;
    assign lb_clr  = ((state_q == ST_IDLE) & req & bad_addr)
                   | ((state_q == ST_RD_WAIT) & ~app_rd_data_valid & (cnt_q == CNT_LAST));

    rvm_ddr3_line_buf u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (lb_clr),
        .tag_i       (mem_addr[27:4]),
        .hit_o       (lb_hit),
        .line_o      (lb_line),
        .fill_i      (lb_fill),
        .fill_tag_i  (addr_q[25:2]),
        .fill_data_i (app_rd_data),
        .wr_i        (lb_wr),
        .wr_data_i   ({4{mem_wdata}}),
        .wr_be_i     (lane_be(mem_addr[3:2], mem_b_en))
    );

    assign rd_hit   = lb_hit & ~mem_w_en;
    assign hit_word = lb_line[{mem_addr[3:2], 5'b00000} +: 32];
`else
    assign rd_hit   = 1'b0;
    assign hit_word = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            app_en_q    <= 1'b0;
            wdf_wren_q  <= 1'b0;
            mem_error_q <= 1'b0;
            rdata_q     <= 32'd0;
            cmd_done_q  <= 1'b0;
            dat_done_q  <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            mem_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        addr_q     <= mem_addr[27:2];
                        wdata_q    <= mem_wdata;
                        be_q       <= mem_b_en;
                        cmd_done_q <= 1'b0;
                        dat_done_q <= 1'b0;
                        cnt_q      <= '0;
                        if (bad_addr) begin
                            state_q     <= ST_RESP;
                            mem_error_q <= 1'b1;
                        end else if (rd_hit) begin
                            state_q <= ST_RESP;
                            rdata_q <= hit_word;
                        end else if (mem_w_en) begin
                            state_q    <= ST_WR;
                            app_en_q   <= 1'b1;
                            wdf_wren_q <= 1'b1;
                        end else begin
                            state_q  <= ST_RD_CMD;
                            app_en_q <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    cmd_done_q <= cmd_done_d;
                    dat_done_q <= dat_done_d;
                    app_en_q   <= ~cmd_done_d;
                    wdf_wren_q <= ~dat_done_d;
                    if (cmd_done_d && dat_done_d) state_q <= ST_RESP;
                end
                ST_RD_CMD: begin
                    if (app_rdy) begin
                        app_en_q <= 1'b0;
                        state_q  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        rdata_q <= app_rd_data[{lane, 5'b00000} +: 32];
                        state_q <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_error_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
